// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer scheduler.
// Provides: FSM state enum, default widths, round-robin pick and pointer-advance functions.
// Optional feature macro: TIMER_SCHED_PRESCALE_EN (adds the prescaler width default).
package timer_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned CNT_W_DEF = 16;
`ifdef TIMER_SCHED_PRESCALE_EN
    localparam int unsigned PRE_W_DEF = 8;
`endif
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First asserted request at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [IDX_W-1:0] ptr,
                                         input logic [MAX_REQ-1:0] req,
                                         input int unsigned n);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            j = 32'(ptr) + i;
            if (j >= n) j = j - n;
            if (i < n && !r.valid && req[j[IDX_W-1:0]]) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(j);
            end
        end
        return r;
    endfunction

    // Index after idx, wrapping modulo n.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                                 input int unsigned n);
        return (32'(idx) + 32'd1 >= n) ? IDX_W'(0) : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// Request/grant bundle between requesters and the timer scheduler.
// Signals: req (per-requester level), dur (packed durations), grant (one-hot owner),
// done (expiry pulse), busy, count (live counter), prescale (only with TIMER_SCHED_PRESCALE_EN).
// master = requester side, slave = scheduler side.
interface timer_scheduler_if
    import timer_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
`ifdef TIMER_SCHED_PRESCALE_EN
    ,
    parameter int unsigned PRE_W = PRE_W_DEF
`endif
) ();

    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] dur;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [CNT_W-1:0]      count;
`ifdef TIMER_SCHED_PRESCALE_EN
    logic [PRE_W-1:0]      prescale;

    modport master (output req, dur, prescale, input grant, done, busy, count);
    modport slave  (input req, dur, prescale, output grant, done, busy, count);
`else
    modport master (output req, dur, input grant, done, busy, count);
    modport slave  (input req, dur, output grant, done, busy, count);
`endif

endinterface

// File: rtl/timer_core.sv
// Shared down-counter with optional prescaler.
// Ports: clk, rst (sync, active-high), load/load_val (preset count), run (count enable),
//        prescale (only with TIMER_SCHED_PRESCALE_EN), count (live value),
//        expire (combinational: a tick lands while count==1).
// Optional feature macro: TIMER_SCHED_PRESCALE_EN.
module timer_core #(
    parameter int unsigned CNT_W = 16
`ifdef TIMER_SCHED_PRESCALE_EN
    ,
    parameter int unsigned PRE_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             run,
`ifdef TIMER_SCHED_PRESCALE_EN
    input  logic [PRE_W-1:0] prescale,
`endif
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic tick;

`ifdef TIMER_SCHED_PRESCALE_EN
    logic [PRE_W-1:0] pre;

    // Prescaler restarts on load and on every tick; prescale is compared live.
    assign tick = (pre == prescale);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            pre <= '0;
        end else if (run) begin
            pre <= tick ? '0 : pre + PRE_W'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign expire = run && tick && (count == CNT_W'(1));

    // Count holds whenever run is low, which is how an abort freezes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && tick && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one down-counting timer between NREQ requesters.
// Ports: clk, rst (sync, active-high), bus (timer_scheduler_if.slave: req, dur, grant,
//        done, busy, count, and prescale when TIMER_SCHED_PRESCALE_EN is defined).
// Optional feature macro: TIMER_SCHED_PRESCALE_EN (prescaled ticks).
module timer_scheduler
    import timer_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
`ifdef TIMER_SCHED_PRESCALE_EN
    ,
    parameter int unsigned PRE_W = PRE_W_DEF
`endif
) (
    input  logic         clk,
    input  logic         rst,
    timer_scheduler_if.slave bus
);

    state_e           state, next_state;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [NREQ-1:0]  grant_q, grant_nxt;
    logic [NREQ-1:0]  done_q, done_nxt;
    logic             busy_q, busy_nxt;

    logic [MAX_REQ-1:0] req_pad;
    logic [CNT_W-1:0]   dur_arr [MAX_REQ];
    logic [CNT_W-1:0]   load_val;
    logic               owner_req;
    logic               load;
    logic               run;
    logic               expire;
    rr_pick_t           pick;

    // Pad request/duration vectors to MAX_REQ so the owner index needs no width juggling.
    assign req_pad = MAX_REQ'(bus.req);

    for (genvar g = 0; g < MAX_REQ; g++) begin : g_dur
        if (g < NREQ) begin : g_used
            assign dur_arr[g] = bus.dur[g*CNT_W +: CNT_W];
        end else begin : g_pad
            assign dur_arr[g] = '0;
        end
    end

    assign pick      = rr_pick(ptr, req_pad, NREQ);
    assign owner_req = req_pad[owner];
    assign load_val  = dur_arr[owner];
    // Owner dropping req suppresses both load and counting (abort holds count).
    assign load      = (state == LOAD) && owner_req;
    assign run       = (state == RUN) && owner_req;

    timer_core #(
        .CNT_W (CNT_W)
`ifdef TIMER_SCHED_PRESCALE_EN
        ,
        .PRE_W (PRE_W)
`endif
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .run      (run),
`ifdef TIMER_SCHED_PRESCALE_EN
        .prescale (bus.prescale),
`endif
        .count    (bus.count),
        .expire   (expire)
    );

    // State register plus registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state   <= next_state;
            owner   <= owner_nxt;
            ptr     <= ptr_nxt;
            grant_q <= grant_nxt;
            done_q  <= done_nxt;
            busy_q  <= busy_nxt;
        end
    end

    // Next-state, arbitration and pointer advance.
    always_comb begin
        next_state = state;
        owner_nxt  = owner;
        ptr_nxt    = ptr;
        case (state)
            IDLE: begin
                if (pick.valid) begin
                    next_state = LOAD;
                    owner_nxt  = pick.idx;
                end
            end
            LOAD: begin
                if (!owner_req) begin
                    next_state = IDLE;
                    ptr_nxt    = rr_next(owner, NREQ);
                end else if (load_val == '0) begin
                    next_state = DONE;
                end else begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    next_state = IDLE;
                    ptr_nxt    = rr_next(owner, NREQ);
                end else if (expire) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
                ptr_nxt    = rr_next(owner, NREQ);
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so grant/done/busy register in step with it.
    always_comb begin
        grant_nxt = '0;
        done_nxt  = '0;
        busy_nxt  = 1'b0;
        if (next_state != IDLE) begin
            grant_nxt = NREQ'(1) << owner_nxt;
            busy_nxt  = 1'b1;
        end
        if (next_state == DONE) begin
            done_nxt = grant_nxt;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level model (owner, age since grant, captured duration).
module tb_timer_scheduler;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned CNT_W = 16;

    logic clk;
    logic rst;

    int n_vec;
    int n_err;
    int cyc;

    // Reference model state
    int               m_owner;
    int               m_age;
    int               m_d;
    int               m_ptr;
    logic [CNT_W-1:0] m_cnt;

    timer_scheduler_if #(
        .NREQ  (NREQ),
        .CNT_W (CNT_W)
`ifdef TIMER_SCHED_PRESCALE_EN
        ,
        .PRE_W (8)
`endif
    ) bus ();

    timer_scheduler #(
        .NREQ  (NREQ),
        .CNT_W (CNT_W)
`ifdef TIMER_SCHED_PRESCALE_EN
        ,
        .PRE_W (8)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Model: a grant opens at age 0; the duration is captured one cycle later (age 1),
    // the counter then shows d, d-1, ..., and expiry occupies age d+1.
    task automatic m_update(input logic r, input logic [NREQ-1:0] rq,
                            input logic [NREQ*CNT_W-1:0] dv);
        bit found;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_cnt = '0; m_age = 0; m_d = 0;
        end else if (m_owner < 0) begin
            found = 0;
            for (int i = 0; i < int'(NREQ); i++) begin
                int j;
                j = (m_ptr + i) % int'(NREQ);
                if (!found && rq[j]) begin
                    found = 1; m_owner = j; m_age = 0;
                end
            end
        end else if (m_age == 0) begin
            if (!rq[m_owner]) begin
                m_ptr = (m_owner + 1) % int'(NREQ); m_owner = -1;
            end else begin
                m_d   = int'(dv[m_owner*CNT_W +: CNT_W]);
                m_cnt = CNT_W'(m_d);
                m_age = 1;
            end
        end else if (m_age == m_d + 1) begin
            m_ptr = (m_owner + 1) % int'(NREQ); m_owner = -1;
        end else if (!rq[m_owner]) begin
            m_ptr = (m_owner + 1) % int'(NREQ); m_owner = -1;
        end else begin
            m_age = m_age + 1;
            if (m_cnt != '0) m_cnt = m_cnt - CNT_W'(1);
        end
    endtask

    function automatic logic [2*NREQ+CNT_W:0] m_exp();
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] d;
        g = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
        d = (m_owner >= 0 && m_age >= 1 && m_age == m_d + 1) ? g : '0;
        return {g, d, (m_owner >= 0), m_cnt};
    endfunction

    // One clock edge; model consumes the inputs the DUT saw, outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        m_update(rst, bus.req, bus.dur);
        cyc++;
        #1;
    endtask

    task automatic set_dur(input int i, input logic [CNT_W-1:0] v);
        bus.dur[i*CNT_W +: CNT_W] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.dur = {$urandom, $urandom};
        cycle();
        cycle();
        n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got=%b want=0000", bus.grant); end
        n_vec++; if (bus.done !== 4'b0000) begin n_err++; $display("FAIL reset_done got=%b want=0000", bus.done); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        n_vec++; if (bus.count !== 16'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        rst = 1'b0;
        bus.req = '0;
    endtask

    task automatic test_single();
        int done_at;
        do_reset();
        set_dur(2, 16'd5);
        bus.req = 4'b0100;
        cycle();
        n_vec++; if (bus.grant !== 4'b0100 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL single_grant got=%b/%b want=0100/1", bus.grant, bus.busy);
        end
        done_at = -1;
        for (int k = 1; k <= 12 && done_at < 0; k++) begin
            cycle();
            n_vec++; if ({bus.grant, bus.done, bus.busy, bus.count} !== m_exp()) begin
                n_err++; $display("FAIL single_model cyc=%0d got=%h want=%h", cyc, {bus.grant, bus.done, bus.busy, bus.count}, m_exp());
            end
            if (k <= 5) begin
                n_vec++; if (bus.count !== 16'(6 - k)) begin
                    n_err++; $display("FAIL single_count step=%0d got=%0d want=%0d", k, bus.count, 6 - k);
                end
            end
            if (bus.done != '0) done_at = k;
        end
        n_vec++; if (done_at != 6) begin n_err++; $display("FAIL single_latency got=%0d want=6", done_at); end
        n_vec++; if (bus.done !== 4'b0100 || bus.count !== 16'd0) begin
            n_err++; $display("FAIL single_done got=%b cnt=%0d want=0100 cnt=0", bus.done, bus.count);
        end
        bus.req = '0;   // dropping in the done cycle must not matter
        cycle();
        n_vec++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 4'b0000) begin
            n_err++; $display("FAIL single_release got=%b/%b/%b want=0000/0/0000", bus.grant, bus.busy, bus.done);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int want[6] = '{0, 1, 3, 0, 1, 3};
        logic [NREQ-1:0] prev;
        do_reset();
        for (int i = 0; i < int'(NREQ); i++) set_dur(i, 16'd2);
        bus.req = 4'b1011;
        prev = '0;
        for (int k = 0; k < 80 && order.size() < 6; k++) begin
            cycle();
            n_vec++; if ({bus.grant, bus.done, bus.busy, bus.count} !== m_exp()) begin
                n_err++; $display("FAIL rr_model cyc=%0d got=%h want=%h", cyc, {bus.grant, bus.done, bus.busy, bus.count}, m_exp());
            end
            if (bus.grant != '0 && prev == '0) begin
                for (int i = 0; i < int'(NREQ); i++) if (bus.grant[i]) order.push_back(i);
            end
            prev = bus.grant;
        end
        n_vec++; if (order.size() != 6) begin n_err++; $display("FAIL rr_timeout got=%0d grants want=6", order.size()); end
        for (int i = 0; i < order.size() && i < 6; i++) begin
            n_vec++; if (order[i] != want[i]) begin
                n_err++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, order[i], want[i]);
            end
        end
        bus.req = '0;
        cycle();
    endtask

    task automatic test_zero_dur();
        do_reset();
        set_dur(1, 16'd0);
        bus.req = 4'b0010;
        cycle();
        n_vec++; if (bus.grant !== 4'b0010 || bus.done !== 4'b0000) begin
            n_err++; $display("FAIL zero_load got=%b/%b want=0010/0000", bus.grant, bus.done);
        end
        cycle();
        n_vec++; if (bus.done !== 4'b0010 || bus.busy !== 1'b1 || bus.count !== 16'd0) begin
            n_err++; $display("FAIL zero_done got=%b/%b/%0d want=0010/1/0", bus.done, bus.busy, bus.count);
        end
        bus.req = '0;
        cycle();
        n_vec++; if ({bus.grant, bus.done, bus.busy} !== 9'd0) begin
            n_err++; $display("FAIL zero_idle got=%b want=0", {bus.grant, bus.done, bus.busy});
        end
    endtask

    task automatic test_abort();
        bit hit;
        do_reset();
        set_dur(0, 16'd10);
        set_dur(1, 16'd3);
        bus.req = 4'b0011;
        cycle();
        n_vec++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL abort_grant got=%b want=0001", bus.grant); end
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            cycle();
            if (bus.count == 16'd6) hit = 1;
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL abort_reach got=%0d want=6", bus.count); end
        bus.req = 4'b0010;
        cycle();
        n_vec++; if (bus.grant !== 4'b0000 || bus.done !== 4'b0000 || bus.busy !== 1'b0 || bus.count !== 16'd6) begin
            n_err++; $display("FAIL abort_drop got=%b/%b/%b/%0d want=0000/0000/0/6", bus.grant, bus.done, bus.busy, bus.count);
        end
        cycle();
        n_vec++; if (bus.grant !== 4'b0010) begin n_err++; $display("FAIL abort_next got=%b want=0010", bus.grant); end
        n_vec++; if ({bus.grant, bus.done, bus.busy, bus.count} !== m_exp()) begin
            n_err++; $display("FAIL abort_model got=%h want=%h", {bus.grant, bus.done, bus.busy, bus.count}, m_exp());
        end
    endtask

    task automatic test_reset_mid_run();
        bit hit;
        do_reset();
        set_dur(0, 16'd8);
        bus.req = 4'b0001;
        cycle();
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            cycle();
            if (bus.count == 16'd3) hit = 1;
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL rstrun_reach got=%0d want=3", bus.count); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_vec++; if ({bus.grant, bus.done, bus.busy, bus.count} !== 25'd0) begin
            n_err++; $display("FAIL rstrun_clear got=%h want=0", {bus.grant, bus.done, bus.busy, bus.count});
        end
        cycle();
        n_vec++; if (bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL rstrun_regrant got=%b/%b want=0001/1", bus.grant, bus.busy);
        end
    endtask

    task automatic test_random();
        do_reset();
        bus.req = NREQ'($urandom);
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
                set_dur(i, CNT_W'($urandom_range(0, 6)));
            end
            rst = ($urandom_range(0, 149) == 0);
            cycle();
            n_vec++; if ({bus.grant, bus.done, bus.busy, bus.count} !== m_exp()) begin
                n_err++; $display("FAIL rand_model cyc=%0d got=%h want=%h", cyc, {bus.grant, bus.done, bus.busy, bus.count}, m_exp());
            end
            n_vec++; if ($countones(bus.grant) > 1 || (bus.done & ~bus.grant) != '0) begin
                n_err++; $display("FAIL rand_invariant cyc=%0d grant=%b done=%b want onehot0/subset", cyc, bus.grant, bus.done);
            end
        end
        rst = 1'b0;
    endtask

`ifdef TIMER_SCHED_PRESCALE_EN
    task automatic test_prescale();
        int done_at;
        do_reset();
        bus.prescale = 8'd3;
        set_dur(0, 16'd4);
        bus.req = 4'b0001;
        cycle();
        done_at = -1;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            cycle();
            if ((k - 1) % 4 == 0 && k <= 13) begin
                n_vec++; if (bus.count !== 16'(4 - (k - 1) / 4)) begin
                    n_err++; $display("FAIL pre_count step=%0d got=%0d want=%0d", k, bus.count, 4 - (k - 1) / 4);
                end
            end
            if (bus.done != '0) done_at = k;
        end
        n_vec++; if (done_at != 17) begin n_err++; $display("FAIL pre_latency got=%0d want=17", done_at); end
        bus.req = '0;
        bus.prescale = '0;
        do_reset();
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        m_owner = -1; m_age = 0; m_d = 0; m_ptr = 0; m_cnt = '0;
        rst = 1'b1;
        bus.req = '0;
        bus.dur = '0;
`ifdef TIMER_SCHED_PRESCALE_EN
        bus.prescale = '0;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_zero_dur();
        test_abort();
        test_reset_mid_run();
        test_random();
`ifdef TIMER_SCHED_PRESCALE_EN
        test_prescale();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
